// File: rtl/fetch_prefetch_queue.sv
// Prefetch queue between the I-cache read port and the IF realigner: runs ahead
// sequentially, buffers {addr, word}, and redirects. `FETCH_BYPASS_EN adds an empty-queue bypass.
module fetch_prefetch_queue #(
  parameter int          DEPTH      = 4,
  parameter logic [29:0] RESET_ADDR = 30'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ICACHE_stall,
  input  logic [31:0] ICACHE_rdata,
  output logic        ICACHE_ren,
  output logic        ICACHE_wen,
  output logic [29:0] ICACHE_addr,
  output logic [31:0] ICACHE_wdata,
  input  logic        redirect,
  input  logic [29:0] redirect_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [29:0] out_addr,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, DISCARD} state_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  state_t          state, state_n;
  logic [29:0]     fetch_addr, fetch_n;
  logic [29:0]     pend_addr, pend_n;
  logic [CW-1:0]   count, count_n;
  logic [PW-1:0]   rd_ptr, rd_n, wr_ptr, wr_n;
  logic            ren_int, complete, bypass, enq, deq;

  assign ICACHE_wen   = 1'b0;
  assign ICACHE_wdata = 32'h0;
  assign ICACHE_addr  = fetch_addr;

  // DISCARD keeps the abandoned request alive until the cache lets go of it.
  assign ren_int    = (state == DISCARD) ? 1'b1 : (count < CW'(DEPTH));
  assign ICACHE_ren = rst_n & ren_int;
  assign complete   = ren_int & ~ICACHE_stall;
  assign head       = mem[rd_ptr];
  assign empty      = (count == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = (state == RUN) & empty & complete & ~redirect;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = ~empty | bypass;
  assign out_data  = bypass ? ICACHE_rdata : head.data;
  assign out_addr  = bypass ? fetch_addr   : head.addr;

  always_comb begin
    state_n = state;
    fetch_n = fetch_addr;
    pend_n  = pend_addr;
    count_n = count;
    rd_n    = rd_ptr;
    wr_n    = wr_ptr;
    enq     = 1'b0;
    deq     = 1'b0;
    if (redirect) begin
      count_n = '0;
      rd_n    = '0;
      wr_n    = '0;
      if (state == RUN) begin
        if (ren_int && ICACHE_stall) begin
          pend_n  = redirect_addr;
          state_n = DISCARD;
        end else begin
          fetch_n = redirect_addr;
        end
      end else begin
        pend_n = redirect_addr;
        if (!ICACHE_stall) begin
          fetch_n = redirect_addr;
          state_n = RUN;
        end
      end
    end else begin
      deq = ~empty & out_ready;
      if (state == RUN) begin
        if (complete) begin
          fetch_n = fetch_addr + 30'd1;
          // A bypassed word taken by IF this cycle never touches storage.
          enq     = ~(bypass & out_ready);
        end
      end else if (!ICACHE_stall) begin
        fetch_n = pend_addr;
        state_n = RUN;
      end
      if (enq) wr_n = wr_ptr + PW'(1);
      if (deq) rd_n = rd_ptr + PW'(1);
      count_n = count + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      fetch_addr <= RESET_ADDR;
      pend_addr  <= RESET_ADDR;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      state      <= state_n;
      fetch_addr <= fetch_n;
      pend_addr  <= pend_n;
      count      <= count_n;
      rd_ptr     <= rd_n;
      wr_ptr     <= wr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{addr: fetch_addr, data: ICACHE_rdata};
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: per-cycle vector table plus reset and bypass sequences.
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ICACHE_stall;
  logic [31:0] ICACHE_rdata;
  logic        ICACHE_ren, ICACHE_wen;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_wdata;
  logic        redirect;
  logic [29:0] redirect_addr;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [29:0] out_addr;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [29:0] raddr;
    logic        ready;
    logic        ren;
    logic [29:0] iaddr;
    logic        valid;
    logic [29:0] oaddr;
  } vec_t;

  vec_t vecs[$];

  fetch_prefetch_queue #(.DEPTH(4), .RESET_ADDR(30'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .ICACHE_stall(ICACHE_stall), .ICACHE_rdata(ICACHE_rdata),
    .ICACHE_ren(ICACHE_ren), .ICACHE_wen(ICACHE_wen),
    .ICACHE_addr(ICACHE_addr), .ICACHE_wdata(ICACHE_wdata),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .empty(empty)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mk_word(input logic [29:0] a);
    return {a[15:0] ^ 16'hBEEF, a[29:14]};
  endfunction

  assign ICACHE_rdata = mk_word(ICACHE_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void add(input logic st, input logic rd, input logic [29:0] ra,
                              input logic rdy, input logic ren, input logic [29:0] ia,
                              input logic v, input logic [29:0] oa);
    vec_t t;
    t.stall = st; t.redir = rd; t.raddr = ra; t.ready = rdy;
    t.ren = ren; t.iaddr = ia; t.valid = v; t.oaddr = oa;
    vecs.push_back(t);
  endfunction

  task automatic step(input vec_t v, input string tag);
    ICACHE_stall  = v.stall;
    redirect      = v.redir;
    redirect_addr = v.raddr;
    out_ready     = v.ready;
    @(negedge clk);
    chk({tag, " ren"},   {31'h0, ICACHE_ren}, {31'h0, v.ren});
    chk({tag, " iaddr"}, {2'b0, ICACHE_addr}, {2'b0, v.iaddr});
    chk({tag, " valid"}, {31'h0, out_valid},  {31'h0, v.valid});
`ifndef FETCH_BYPASS_EN
    chk({tag, " empty"}, {31'h0, empty},      {31'h0, ~v.valid});
`endif
    if (v.valid) begin
      chk({tag, " oaddr"}, {2'b0, out_addr}, {2'b0, v.oaddr});
      chk({tag, " odata"}, out_data, mk_word(v.oaddr));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ICACHE_stall = 1'b0; redirect = 1'b0;
    redirect_addr = 30'h0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst ren",   {31'h0, ICACHE_ren}, 32'h0);
    chk("rst valid", {31'h0, out_valid},  32'h0);
    chk("rst empty", {31'h0, empty},      32'h1);
    chk("rst iaddr", {2'b0, ICACHE_addr}, 32'h0);
    chk("wen tie",   {31'h0, ICACHE_wen}, 32'h0);
    chk("wdata tie", ICACHE_wdata,        32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

`ifndef FETCH_BYPASS_EN
    //   st rd raddr         rdy ren iaddr         v  oaddr
    add(0, 0, 30'h0,        1,  1, 30'h0,        0, 30'h0);
    add(0, 0, 30'h0,        1,  1, 30'h1,        1, 30'h0);
    add(0, 0, 30'h0,        1,  1, 30'h2,        1, 30'h1);
    add(0, 0, 30'h0,        1,  1, 30'h3,        1, 30'h2);
    add(0, 0, 30'h0,        0,  1, 30'h4,        1, 30'h3);   // fill
    add(0, 0, 30'h0,        0,  1, 30'h5,        1, 30'h3);
    add(0, 0, 30'h0,        0,  1, 30'h6,        1, 30'h3);
    add(0, 0, 30'h0,        0,  0, 30'h7,        1, 30'h3);   // full
    add(0, 0, 30'h0,        0,  0, 30'h7,        1, 30'h3);
    add(0, 0, 30'h0,        1,  0, 30'h7,        1, 30'h3);   // drain
    add(0, 0, 30'h0,        1,  1, 30'h7,        1, 30'h4);
    add(0, 0, 30'h0,        1,  1, 30'h8,        1, 30'h5);
    add(0, 0, 30'h0,        1,  1, 30'h9,        1, 30'h6);
    add(0, 0, 30'h0,        1,  1, 30'hA,        1, 30'h7);
    add(0, 1, 30'h100,      1,  1, 30'hB,        1, 30'h8);   // flush
    add(0, 0, 30'h0,        1,  1, 30'h100,      0, 30'h0);
    add(0, 0, 30'h0,        1,  1, 30'h101,      1, 30'h100);
    add(1, 0, 30'h0,        1,  1, 30'h102,      1, 30'h101);
    add(1, 1, 30'h40,       1,  1, 30'h102,      0, 30'h0);   // redirect mid-stall
    add(1, 0, 30'h0,        1,  1, 30'h102,      0, 30'h0);
    add(0, 0, 30'h0,        1,  1, 30'h102,      0, 30'h0);
    add(0, 0, 30'h0,        1,  1, 30'h40,       0, 30'h0);
    add(0, 0, 30'h0,        1,  1, 30'h41,       1, 30'h40);
    add(1, 0, 30'h0,        1,  1, 30'h42,       1, 30'h41);
    add(1, 1, 30'h40,       1,  1, 30'h42,       0, 30'h0);   // two redirects
    add(1, 1, 30'h80,       1,  1, 30'h42,       0, 30'h0);
    add(0, 0, 30'h0,        1,  1, 30'h42,       0, 30'h0);
    add(0, 0, 30'h0,        1,  1, 30'h80,       0, 30'h0);
    add(0, 0, 30'h0,        1,  1, 30'h81,       1, 30'h80);
    add(1, 0, 30'h0,        1,  1, 30'h82,       1, 30'h81);
    add(1, 1, 30'h200,      1,  1, 30'h82,       0, 30'h0);
    add(0, 1, 30'h300,      1,  1, 30'h82,       0, 30'h0);   // redirect as stall drops
    add(0, 0, 30'h0,        1,  1, 30'h300,      0, 30'h0);
    add(0, 0, 30'h0,        1,  1, 30'h301,      1, 30'h300);
    add(0, 1, 30'h3FFFFFFE, 1,  1, 30'h302,      1, 30'h301);
    add(0, 0, 30'h0,        1,  1, 30'h3FFFFFFE, 0, 30'h0);
    add(0, 0, 30'h0,        1,  1, 30'h3FFFFFFF, 1, 30'h3FFFFFFE);
    add(0, 0, 30'h0,        1,  1, 30'h0,        1, 30'h3FFFFFFF);  // wrap
    add(0, 0, 30'h0,        1,  1, 30'h1,        1, 30'h0);
    add(0, 0, 30'h0,        0,  1, 30'h2,        1, 30'h1);
    add(0, 0, 30'h0,        0,  1, 30'h3,        1, 30'h1);
    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // Three entries queued, request to addr 4 stalled, then reset mid-cycle.
    ICACHE_stall = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("pre-rst ren",   {31'h0, ICACHE_ren}, 32'h1);
    chk("pre-rst iaddr", {2'b0, ICACHE_addr}, 32'h4);
    chk("pre-rst oaddr", {2'b0, out_addr},    32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async ren",   {31'h0, ICACHE_ren}, 32'h0);
    chk("async valid", {31'h0, out_valid},  32'h0);
    chk("async empty", {31'h0, empty},      32'h1);
    chk("async iaddr", {2'b0, ICACHE_addr}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    vecs.delete();
    add(0, 0, 30'h0, 1, 1, 30'h0, 0, 30'h0);
    add(0, 0, 30'h0, 1, 1, 30'h1, 1, 30'h0);
    add(0, 0, 30'h0, 1, 1, 30'h2, 1, 30'h1);
    foreach (vecs[i]) step(vecs[i], $sformatf("post%0d", i));
`else
    add(0, 0, 30'h0, 1, 1, 30'h0, 1, 30'h0);   // bypass, consumed
    add(0, 0, 30'h0, 0, 1, 30'h1, 1, 30'h1);   // bypass, enqueued
    add(1, 0, 30'h0, 0, 1, 30'h2, 1, 30'h1);
    add(1, 0, 30'h0, 1, 1, 30'h2, 1, 30'h1);
    add(1, 0, 30'h0, 1, 1, 30'h2, 0, 30'h0);
    foreach (vecs[i]) step(vecs[i], $sformatf("byp%0d", i));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Sits directly upstream of the IF stage, between the I-cache port and the IF realigner.
- Runs ahead of the pipeline: issues sequential word-aligned I-cache reads and buffers the returned {word address, instruction word} pairs in a small FIFO.
- IF consumes words through a valid/ready handshake and redirects the stream on jumps, taken branches and predicted branches.
- Hides I-cache stall bubbles from IF when IF itself is stalled.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_ADDR, 30'h0, word address fetched first after reset.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ICACHE_stall  input  1  cache busy; request completes only in a cycle with ICACHE_ren=1 and ICACHE_stall=0
- ICACHE_rdata  input  32  read data, valid in the completing cycle
- ICACHE_ren  output  1  read request
- ICACHE_wen  output  1  tied 0
- ICACHE_addr  output  30  word address of request
- ICACHE_wdata  output  32  tied 0
- redirect  input  1  flush queue and restart at redirect_addr
- redirect_addr  input  30  new word address
- out_valid  output  1  head entry valid
- out_ready  input  1  IF accepts head this cycle
- out_data  output  32  head instruction word
- out_addr  output  30  head word address
- empty  output  1  count==0 (debug/IF idle detect)

Behaviour:
- Reset is asynchronous, active-low.
  - Values during and after reset: state=RUN, fetch_addr=RESET_ADDR, count=0, rd/wr pointers=0, out_valid=0, ICACHE_ren=0 while rst_n low, empty=1.
  - Reset asserted mid-request abandons the request. No data from it is ever enqueued.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- ICACHE_addr = fetch_addr at all times.
- ICACHE_addr is held stable while ICACHE_stall=1 and ren=1.
- States:
  - RUN:
    - ICACHE_ren = (count < DEPTH).
    - Completion (ren & !ICACHE_stall, no redirect): enqueue {fetch_addr, ICACHE_rdata}, then fetch_addr <= fetch_addr+1.
  - DISCARD:
    - ICACHE_ren = 1, and ICACHE_addr is held at the abandoned address.
    - On !ICACHE_stall: drop the returned data, fetch_addr <= pend_addr, go to RUN.
- Dequeue: out_valid=1 iff count!=0. out_data/out_addr are the head entry, driven straight from storage. out_valid & out_ready pops the head.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. Enqueue into a full queue cannot happen because ren=0 when full.
- redirect=1 has priority over everything in the same cycle:
  - FIFO is flushed: count, rd_ptr and wr_ptr are cleared. out_valid=0 from the next cycle.
  - Any dequeue and any completion in that cycle are dropped.
  - In RUN with ren=1 and ICACHE_stall=1: pend_addr <= redirect_addr, go to DISCARD.
  - Otherwise: fetch_addr <= redirect_addr. The first request to the new address is issued the next cycle.
  - In DISCARD: pend_addr is overwritten (the last redirect wins).
    - If ICACHE_stall=0 in that same cycle, fetch_addr <= redirect_addr and state goes to RUN.
- Latency: completion in cycle N gives out_valid in cycle N+1. Redirect in cycle N gives the new-address request in cycle N+1 (non-stalled case).
- fetch_addr wraps from 30'h3FFFFFFF to 0 with no error.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- When defined:
  - If count==0 and a completion occurs with no redirect, out_valid=1 in the same cycle, with out_data=ICACHE_rdata and out_addr=fetch_addr.
  - If out_ready=1 as well, the word is consumed and not enqueued. Otherwise it is enqueued normally.
- When not defined: one-cycle minimum latency as stated above, and outputs come only from storage.

Test Plan:
- Reset release with RESET_ADDR=0, ICACHE_stall=0, out_ready=1 -> ICACHE_addr 0,1,2,3 on consecutive cycles; out_addr 0,1,2 appear one cycle later; out_data matches the model.
- out_ready=0, no stall -> exactly 4 words enqueued, then ICACHE_ren=0. Raise out_ready -> the 4 words drain in order and fetching resumes at addr 4.
- Queue holding 2 entries, redirect to 30'h100 with ICACHE_stall=0 -> out_valid=0 next cycle; the next request is 30'h100 and no stale word is ever output.
- Request to addr 5 stalled for 3 cycles, redirect to 30'h40 in stall cycle 1 -> ICACHE_addr stays 5 until the stall drops; that data is dropped; the next request is 30'h40.
- Two redirects during one stall (30'h40, then 30'h80) -> only 30'h80 is fetched afterwards.
- Assert rst_n=0 mid-stall with 3 entries queued -> out_valid=0 and ICACHE_ren=0 immediately (asynchronous); after release, fetch restarts at RESET_ADDR. With FETCH_BYPASS_EN on an empty queue, the completion cycle shows out_valid=1.
